axis_frame_len_fifo: RTL and testbench
======================================

Name: axis_frame_len_fifo

Overview:
Passive length tap for an AXI-Stream byte or word path, e.g. the MAC RX output in the `rx_clk` domain. It counts bytes per frame using `tkeep`, classifies each frame as bad, oversize or undersize, and queues one length record per frame into an internal single-clock FIFO with its own AXI-Stream output. It supersedes the fixed-width 8-bit length counter: configurable data width, length width, depth, size limits and bad-frame filtering, plus overflow reporting.

Parameters:
DATA_WIDTH, 8, width of the tapped stream in bits; must be a multiple of 8.
KEEP_ENABLE, (DATA_WIDTH>8), 1 = bytes per beat taken from `tkeep`; 0 = every beat counts KEEP_WIDTH bytes.
KEEP_WIDTH, (DATA_WIDTH/8), byte lanes per beat.
LEN_WIDTH, 16, width of the length field; the counter saturates at 2^LEN_WIDTH-1.
DEPTH, 64, record FIFO depth; must be a power of two, at least 2.
MIN_LEN, 64, frames shorter than this set the undersize flag.
MAX_LEN, 1522, frames longer than this set the oversize flag.
DROP_BAD_FRAME, 0, 1 = frames with a bad `tuser` produce no record.

Ports:
clk  in  1  block clock, shared with the tapped stream
rst  in  1  asynchronous, active-high reset
monitor_axis_tkeep  in  KEEP_WIDTH  tapped byte enables
monitor_axis_tvalid  in  1  tapped valid
monitor_axis_tready  in  1  tapped ready; tie to 1 for a stream with no backpressure
monitor_axis_tlast  in  1  tapped last
monitor_axis_tuser  in  1  tapped user bit; 1 marks a bad frame
m_len_tdata  out  LEN_WIDTH  frame length in bytes
m_len_tuser  out  3  bit0 = bad, bit1 = oversize, bit2 = undersize
m_len_tvalid  out  1  record available
m_len_tready  in  1  record consumed
m_len_tlast  out  1  constant 1
fifo_level  out  $clog2(DEPTH)+1  records currently stored
status_overflow  out  1  one-cycle pulse: a record was lost because the FIFO was full
status_good_frame  out  1  one-cycle pulse: a good frame ended
status_bad_frame  out  1  one-cycle pulse: a bad frame ended

Behaviour:
- Beat: `monitor_axis_tvalid & monitor_axis_tready`. All other cycles are ignored.
- Bytes per beat (bpb):
  - KEEP_ENABLE=1: popcount of `tkeep`; non-contiguous masks are counted as-is.
  - KEEP_ENABLE=0: KEEP_WIDTH.
- Length counter `cnt`, reset 0:
  - Non-last beat: `cnt <= sat(cnt + bpb)`.
  - Last beat: `total = sat(cnt + bpb)`, then `cnt <= 0`.
  - A last beat with bpb=0 gives total = cnt.
- Saturation: the sum is computed at LEN_WIDTH+1 bits and clamped to 2^LEN_WIDTH-1. A saturated frame forces the oversize flag.
- Flags, evaluated on the last beat:
  - bad = `tuser`.
  - oversize = (total > MAX_LEN) or saturated.
  - undersize = (total < MIN_LEN).
- Push on the last beat unless (DROP_BAD_FRAME and bad).
- Full handling:
  - The full check uses the registered level only; a pop in the same cycle does not free space.
  - A push while full: no write, the FIFO is unchanged, and `status_overflow` pulses one cycle later.
- Status pulses:
  - `status_good_frame` / `status_bad_frame` are registered and asserted the cycle after the last beat.
  - They fire regardless of drop or overflow.
- FIFO:
  - Write and read pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - Output is first-word fall-through: `m_len_tvalid` = !empty.
  - `m_len_tdata` / `m_len_tuser` hold the head record and are stable while tvalid=1 and tready=0.
  - Pop on `m_len_tvalid & m_len_tready`.
- Latency: a record pushed at the last beat in cycle N is visible at the output in cycle N+1.
- Simultaneous push and pop when not full: both occur and the level is unchanged.
- `fifo_level` is registered, 0..DEPTH.
- Reset (asynchronous, any time, including mid-frame):
  - `cnt`, pointers and level go to 0.
  - All status pulses go to 0; `m_len_tvalid` goes to 0.
  - A partial frame in progress is discarded; the first beat after reset release starts a new frame at 0.
- `m_len_tlast` is tied to 1.

Optional Feature:
FRAME_LEN_FIFO_STATS_EN defined:
- Adds an input `stat_clear` (1 bit).
- Adds three 32-bit saturating counter outputs:
  - `stat_good_frames`: increments with `status_good_frame`.
  - `stat_bad_frames`: increments with `status_bad_frame`.
  - `stat_dropped`: increments on an overflow loss or a DROP_BAD_FRAME discard.
- All three reset to 0.
- `stat_clear` zeroes them synchronously and takes priority over an increment in the same cycle.

FRAME_LEN_FIFO_STATS_EN undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- DATA_WIDTH=64: 8 full beats, then a last beat with `tkeep`=8'h0F and `tuser`=0 -> one record, length 68, tuser=3'b000; `status_good_frame` pulses once.
- DATA_WIDTH=8: a 40-byte frame, then a 1600-byte frame with `tuser`=1 on the last byte -> records (40, 3'b100) and (1600, 3'b011); with DROP_BAD_FRAME=1 only (40, 3'b100).
- LEN_WIDTH=8, DATA_WIDTH=8: a 300-byte frame -> length 255, oversize=1; the next 10-byte frame gives length 10.
- DEPTH=4, m_len_tready=0: 6 frames of 64 bytes -> fifo_level=4, two `status_overflow` pulses. Then drain -> exactly 4 records of 64, order preserved.
- Back-to-back 1-byte frames every cycle with m_len_tready=1 -> each record appears the cycle after its last beat; fifo_level never exceeds 1.
- Assert rst after 30 bytes of a frame, release, then send a 64-byte frame -> single record of 64; no record from the partial frame.

Source files
------------

// File: rtl/axis_frame_len_fifo.sv
// axis_frame_len_fifo: per-frame byte-length tap queuing {flags,len} records in a FWFT FIFO (optional stats: FRAME_LEN_FIFO_STATS_EN)
module axis_frame_len_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = 16,
  parameter int DEPTH          = 64,
  parameter int MIN_LEN        = 64,
  parameter int MAX_LEN        = 1522,
  parameter int DROP_BAD_FRAME = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEEP_WIDTH-1:0]  monitor_axis_tkeep,
  input  logic                   monitor_axis_tvalid,
  input  logic                   monitor_axis_tready,
  input  logic                   monitor_axis_tlast,
  input  logic                   monitor_axis_tuser,
  output logic [LEN_WIDTH-1:0]   m_len_tdata,
  output logic [2:0]             m_len_tuser,
  output logic                   m_len_tvalid,
  input  logic                   m_len_tready,
  output logic                   m_len_tlast,
  output logic [$clog2(DEPTH):0] fifo_level,
`ifdef FRAME_LEN_FIFO_STATS_EN
  input  logic                   stat_clear,
  output logic [31:0]            stat_good_frames,
  output logic [31:0]            stat_bad_frames,
  output logic [31:0]            stat_dropped,
`endif
  output logic                   status_overflow,
  output logic                   status_good_frame,
  output logic                   status_bad_frame
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = LEN_WIDTH + 3;
  logic beat, last, push, full, wr, rd, sat;
  logic [LEN_WIDTH:0] bpb, sum;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, total;
  logic sat_q, sat_d, ovf_q, ovf_d, good_q, good_d, bad_q, bad_d;
  logic [2:0] flags;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, lvl_q, lvl_d;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] head;
  always_comb begin
    bpb = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      bpb = bpb + (LEN_WIDTH+1)'(KEEP_ENABLE == 0 || monitor_axis_tkeep[i]);
    beat = monitor_axis_tvalid & monitor_axis_tready;
    last = beat & monitor_axis_tlast;
    sum = {1'b0, cnt_q} + bpb;
    sat = sat_q | sum[LEN_WIDTH];
    total = sat ? '1 : sum[LEN_WIDTH-1:0];
    flags = {32'(total) < 32'(MIN_LEN), sat || 32'(total) > 32'(MAX_LEN), monitor_axis_tuser};
    cnt_d = !beat ? cnt_q : (last ? '0 : total);
    sat_d = !beat ? sat_q : (!last && sat);
    push = last & !(DROP_BAD_FRAME != 0 && monitor_axis_tuser);
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    wr = push & !full;
    rd = m_len_tvalid & m_len_tready;
    wp_d = wp_q + (AW+1)'(wr);
    rp_d = rp_q + (AW+1)'(rd);
    lvl_d = lvl_q + (AW+1)'(wr) - (AW+1)'(rd);
    ovf_d = push & full;
    good_d = last & !monitor_axis_tuser;
    bad_d = last & monitor_axis_tuser;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      good_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      good_q <= good_d;
      bad_q <= bad_d;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp_q[AW-1:0]] <= {flags, total};
  assign head = mem[rp_q[AW-1:0]];
  assign m_len_tdata = head[LEN_WIDTH-1:0];
  assign m_len_tuser = head[RW-1:LEN_WIDTH];
  assign m_len_tvalid = wp_q != rp_q;
  assign m_len_tlast = 1'b1;
  assign fifo_level = lvl_q;
  assign status_overflow = ovf_q;
  assign status_good_frame = good_q;
  assign status_bad_frame = bad_q;
`ifdef FRAME_LEN_FIFO_STATS_EN
  logic drop_q, drop_d;
  logic [31:0] sg_q, sg_d, sb_q, sb_d, sd_q, sd_d;
  always_comb begin
    drop_d = last & monitor_axis_tuser & (DROP_BAD_FRAME != 0);
    sg_d = stat_clear ? '0 : sg_q + 32'(good_q && sg_q != '1);
    sb_d = stat_clear ? '0 : sb_q + 32'(bad_q && sb_q != '1);
    sd_d = stat_clear ? '0 : sd_q + 32'((ovf_q || drop_q) && sd_q != '1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      drop_q <= 1'b0;
      sg_q <= '0;
      sb_q <= '0;
      sd_q <= '0;
    end else begin
      drop_q <= drop_d;
      sg_q <= sg_d;
      sb_q <= sb_d;
      sd_q <= sd_d;
    end
  assign stat_good_frames = sg_q;
  assign stat_bad_frames = sb_q;
  assign stat_dropped = sd_q;
`endif
endmodule

// File: tb/tb_axis_frame_len_fifo.sv
// tb_axis_frame_len_fifo: scoreboard bench driving a 64-bit and an 8-bit instance from one stimulus stream
module tb_axis_frame_len_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tkeep = 8'h00;
  logic tvalid = 1'b0, tready = 1'b1, tlast = 1'b0, tuser = 1'b0, len_tready = 1'b1;
  logic [15:0] d0_len;
  logic [7:0] d1_len;
  logic [2:0] d0_fl, d1_fl, d0_lvl, d1_lvl;
  logic d0_v, d0_l, d0_ov, d0_g, d0_b, d1_v, d1_l, d1_ov, d1_g, d1_b;
  axis_frame_len_fifo #(.DATA_WIDTH(64), .LEN_WIDTH(16), .DEPTH(4), .MIN_LEN(64), .MAX_LEN(1522), .DROP_BAD_FRAME(0)) d0 (
    .clk(clk), .rst(rst), .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .monitor_axis_tuser(tuser),
    .m_len_tdata(d0_len), .m_len_tuser(d0_fl), .m_len_tvalid(d0_v), .m_len_tready(len_tready),
    .m_len_tlast(d0_l), .fifo_level(d0_lvl), .status_overflow(d0_ov),
    .status_good_frame(d0_g), .status_bad_frame(d0_b));
  axis_frame_len_fifo #(.DATA_WIDTH(8), .LEN_WIDTH(8), .DEPTH(4), .MIN_LEN(16), .MAX_LEN(200), .DROP_BAD_FRAME(1)) d1 (
    .clk(clk), .rst(rst), .monitor_axis_tkeep(tkeep[0:0]), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .monitor_axis_tuser(tuser),
    .m_len_tdata(d1_len), .m_len_tuser(d1_fl), .m_len_tvalid(d1_v), .m_len_tready(len_tready),
    .m_len_tlast(d1_l), .fifo_level(d1_lvl), .status_overflow(d1_ov),
    .status_good_frame(d1_g), .status_bad_frame(d1_b));
  always #5 clk = ~clk;
  typedef struct {int len; logic [2:0] fl;} rec_t;
  typedef struct {int nb; logic [7:0] keep; logic user; int len0; logic [2:0] fl0; int len1; logic [2:0] fl1;} vec_t;
  rec_t q0[$], q1[$];
  rec_t e0, e1;
  vec_t tbl[8];
  int checks = 0, errors = 0, max_lvl = 0, ovc0 = 0, ovc1 = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle();
    logic lb, f0, f1, ov0, ov1, g, b;
    rec_t r;
    lb = tvalid && tready && tlast;
    f0 = q0.size() == 4;
    f1 = q1.size() == 4;
    if (len_tready && q0.size() != 0) begin
      r = q0.pop_front();
      chk("d0_len", int'(d0_len), r.len);
      chk("d0_flags", int'(d0_fl), int'(r.fl));
    end
    if (len_tready && q1.size() != 0) begin
      r = q1.pop_front();
      chk("d1_len", int'(d1_len), r.len);
      chk("d1_flags", int'(d1_fl), int'(r.fl));
    end
    ov0 = lb && f0;
    ov1 = lb && !tuser && f1;
    g = lb && !tuser;
    b = lb && tuser;
    if (lb && !f0) q0.push_back(e0);
    if (lb && !tuser && !f1) q1.push_back(e1);
    @(posedge clk);
    #1;
    chk("d0_overflow", int'(d0_ov), int'(ov0));
    chk("d1_overflow", int'(d1_ov), int'(ov1));
    chk("d0_good", int'(d0_g), int'(g));
    chk("d0_bad", int'(d0_b), int'(b));
    chk("d1_good", int'(d1_g), int'(g));
    chk("d1_bad", int'(d1_b), int'(b));
    chk("d0_level", int'(d0_lvl), q0.size());
    chk("d1_level", int'(d1_lvl), q1.size());
    chk("d0_valid", int'(d0_v), int'(q0.size() != 0));
    chk("d1_valid", int'(d1_v), int'(q1.size() != 0));
    chk("d0_tlast", int'(d0_l), 1);
    chk("d1_tlast", int'(d1_l), 1);
    ovc0 += int'(d0_ov);
    ovc1 += int'(d1_ov);
    if (int'(d0_lvl) > max_lvl) max_lvl = int'(d0_lvl);
  endtask
  task automatic send_frame(int nb, logic [7:0] keep, logic user, int l0, logic [2:0] f0, int l1, logic [2:0] f1);
    e0 = '{l0, f0};
    e1 = '{l1, f1};
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1 && nb > 2) begin
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tuser = ~user; tkeep = 8'hFF;
        cycle();
      end
      tvalid = 1'b1; tready = 1'b1; tlast = (i == nb - 1); tuser = user;
      tkeep = (i == nb - 1) ? keep : 8'hFF;
      cycle();
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tready = 1'b1;
  endtask
  initial begin
    tbl[0] = '{9,   8'h0F, 1'b0, 68,   3'b000, 9,   3'b100};
    tbl[1] = '{5,   8'hFF, 1'b0, 40,   3'b100, 5,   3'b100};
    tbl[2] = '{200, 8'h03, 1'b1, 1594, 3'b011, 0,   3'b000};
    tbl[3] = '{300, 8'hFF, 1'b0, 2400, 3'b010, 255, 3'b010};
    tbl[4] = '{20,  8'h00, 1'b0, 152,  3'b000, 20,  3'b000};
    tbl[5] = '{10,  8'hA5, 1'b0, 76,   3'b000, 10,  3'b100};
    tbl[6] = '{201, 8'hFF, 1'b0, 1608, 3'b010, 201, 3'b010};
    tbl[7] = '{8,   8'h01, 1'b1, 57,   3'b101, 0,   3'b000};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_d0_level", int'(d0_lvl), 0);
    chk("reset_d0_valid", int'(d0_v), 0);
    chk("reset_d1_valid", int'(d1_v), 0);
    chk("reset_d0_good", int'(d0_g), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].nb, tbl[k].keep, tbl[k].user, tbl[k].len0, tbl[k].fl0, tbl[k].len1, tbl[k].fl1);
      repeat (2) cycle();
    end
    len_tready = 1'b0;
    repeat (6) send_frame(8, 8'hFF, 1'b0, 64, 3'b000, 8, 3'b100);
    cycle();
    chk("full_d0_level", int'(d0_lvl), 4);
    chk("full_d1_level", int'(d1_lvl), 4);
    chk("d0_overflow_pulses", ovc0, 2);
    chk("d1_overflow_pulses", ovc1, 2);
    len_tready = 1'b1;
    repeat (6) cycle();
    chk("drained_d0_level", int'(d0_lvl), 0);
    max_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      tvalid = 1'b1; tready = 1'b1; tlast = 1'b1; tkeep = 8'h01; tuser = i[0];
      e0 = '{1, {2'b10, tuser}};
      e1 = '{1, 3'b100};
      cycle();
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    repeat (2) cycle();
    chk("b2b_max_level", max_lvl, 1);
    for (int i = 0; i < 30; i++) begin
      tvalid = 1'b1; tready = 1'b1; tlast = 1'b0; tkeep = 8'hFF;
      cycle();
    end
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_d0_level", int'(d0_lvl), 0);
    chk("async_rst_d0_valid", int'(d0_v), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tvalid = 1'b0;
    q0.delete();
    q1.delete();
    send_frame(8, 8'hFF, 1'b0, 64, 3'b000, 8, 3'b100);
    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
